// File: rtl/freq_read_arbiter_pkg.sv
// Shared types and constants for the frequency-bank read arbiter.
// Holds the FSM state encoding and the bank geometry.
package freq_read_arbiter_pkg;

    localparam int FREQ_WIDTH      = 26;
    localparam int BANK_ADDR_WIDTH = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant with a 1-bit pointer.
// The pointer moves to the losing requester on every accept.
module rr_arbiter2
    import freq_read_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req_valid,
    input  logic       grant_en,
    output logic [1:0] grant,
    output logic       grant_idx
);

    logic rr_q;
    logic rr_d;
    logic accept;

    always_comb begin
        grant_idx = 1'b0;
        unique case (req_valid)
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = rr_q;
            default: grant_idx = 1'b0;
        endcase
        accept = grant_en && (req_valid != 2'b00);
        grant  = 2'b00;
        if (accept) begin
            grant[grant_idx] = 1'b1;
        end
        rr_d = rr_q;
        if (accept) begin
            rr_d = ~grant_idx;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end

endmodule

// File: rtl/freq_read_arbiter.sv
// Arbitrates display/reporter reads of the frequency bank.
// One transaction in flight: accept, read, hold response until taken.
module freq_read_arbiter
    import freq_read_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = FREQ_WIDTH,
    parameter int ADDR_WIDTH = BANK_ADDR_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [1:0]              req_valid,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    output logic [1:0]              req_ready,
    output logic [1:0]              rsp_valid,
    input  logic [1:0]              rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic [ADDR_WIDTH-1:0]   mem_addr_r,
    input  logic [DATA_WIDTH-1:0]   mem_data_r
);

    state_e                  state_q, state_d;
    logic                    idx_q, idx_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [1:0]              grant;
    logic                    grant_idx;
    logic                    grant_en;

    // Gated by reset_n so req_ready is low while reset is held.
    assign grant_en = (state_q == ST_IDLE) && reset_n;

    rr_arbiter2 u_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .grant_en  (grant_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        data_d  = data_q;
        unique case (state_q)
            ST_IDLE: begin
                if (grant != 2'b00) begin
                    state_d = ST_READ;
                    idx_d   = grant_idx;
                    addr_d  = grant_idx ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                        : req_addr[ADDR_WIDTH-1:0];
                end
            end
            ST_READ: begin
                data_d  = mem_data_r;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready[idx_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rsp_valid = 2'b00;
        if (state_q == ST_RESP) begin
            rsp_valid[idx_q] = 1'b1;
        end
    end

    assign req_ready  = grant;
    assign rsp_data   = data_q;
    assign mem_addr_r = addr_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            idx_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_freq_read_arbiter.sv
// Directed bench for freq_read_arbiter with a behavioural bank model.
// Table vectors for grant order plus hand sequences for stall/reset/hazard.
module tb_freq_read_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  req_valid;
    logic [3:0]  req_addr;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [25:0] rsp_data;
    logic [1:0]  mem_addr_r;
    logic [25:0] mem_data_r;
    logic [25:0] bank [4];

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [1:0]  v;
        logic [1:0]  a0;
        logic [1:0]  a1;
        logic [1:0]  g;
        logic [1:0]  addr;
        logic [25:0] data;
    } vec_t;

    vec_t tbl [9];

    always #5 clk = ~clk;

    assign mem_data_r = bank[mem_addr_r];

    freq_read_arbiter #(.DATA_WIDTH(26), .ADDR_WIDTH(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .mem_addr_r (mem_addr_r),
        .mem_data_r (mem_data_r)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Starts in IDLE just after a negedge; returns on the edge ending READ.
    task automatic accept_read(input logic [1:0] v, input logic [1:0] a0,
                               input logic [1:0] a1, input logic [1:0] g,
                               input logic [1:0] addr);
        req_valid = v;
        req_addr  = {a1, a0};
        #1;
        chk("req_ready_accept", 32'(req_ready), 32'(g));
        @(posedge clk);
        #1;
        req_addr = ~req_addr;
        @(negedge clk);
        chk("mem_addr_read", 32'(mem_addr_r), 32'(addr));
        chk("req_ready_read", 32'(req_ready), 32'd0);
        chk("rsp_valid_read", 32'(rsp_valid), 32'd0);
        @(posedge clk);
    endtask

    task automatic resp_check(input logic [1:0] g, input logic [25:0] d);
        @(negedge clk);
        chk("rsp_valid_resp", 32'(rsp_valid), 32'(g));
        chk("rsp_data_resp", 32'(rsp_data), 32'(d));
        chk("req_ready_resp", 32'(req_ready), 32'd0);
    endtask

    task automatic finish_resp(input logic [1:0] g);
        rsp_ready = g;
        @(posedge clk);
        #1;
        rsp_ready = 2'b00;
        req_valid = 2'b00;
        @(negedge clk);
        chk("rsp_valid_idle", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        tbl[0] = '{2'b11, 2'd1, 2'd3, 2'b01, 2'd1, 26'd222};
        tbl[1] = '{2'b11, 2'd1, 2'd3, 2'b10, 2'd3, 26'd4444};
        tbl[2] = '{2'b11, 2'd1, 2'd3, 2'b01, 2'd1, 26'd222};
        tbl[3] = '{2'b01, 2'd2, 2'd0, 2'b01, 2'd2, 26'd1000};
        tbl[4] = '{2'b10, 2'd3, 2'd0, 2'b10, 2'd0, 26'd11};
        tbl[5] = '{2'b10, 2'd1, 2'd2, 2'b10, 2'd2, 26'd1000};
        tbl[6] = '{2'b11, 2'd0, 2'd1, 2'b01, 2'd0, 26'd11};
        tbl[7] = '{2'b01, 2'd3, 2'd2, 2'b01, 2'd3, 26'd4444};
        tbl[8] = '{2'b11, 2'd2, 2'd1, 2'b10, 2'd1, 26'd222};

        bank[0] = 26'd11;
        bank[1] = 26'd222;
        bank[2] = 26'd1000;
        bank[3] = 26'd4444;

        reset_n   = 1'b0;
        req_valid = 2'b11;
        req_addr  = 4'hF;
        rsp_ready = 2'b11;
        #12;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr_r), 32'd0);
        @(negedge clk);
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        reset_n   = 1'b1;

        for (int i = 0; i < 9; i++) begin
            accept_read(tbl[i].v, tbl[i].a0, tbl[i].a1, tbl[i].g, tbl[i].addr);
            resp_check(tbl[i].g, tbl[i].data);
            finish_resp(tbl[i].g);
        end

        // Stall in RESP: wrong-index ready and pending requests ignored.
        accept_read(2'b11, 2'd2, 2'd0, 2'b01, 2'd2);
        rsp_ready = 2'b10;
        for (int i = 0; i < 5; i++) begin
            resp_check(2'b01, 26'd1000);
        end
        finish_resp(2'b01);

        // Bank write on the edge ending READ returns the old value.
        bank[1] = 26'd500;
        accept_read(2'b01, 2'd1, 2'd0, 2'b01, 2'd1);
        bank[1] <= 26'd700;
        resp_check(2'b01, 26'd500);
        finish_resp(2'b01);
        accept_read(2'b01, 2'd1, 2'd0, 2'b01, 2'd1);
        resp_check(2'b01, 26'd700);
        finish_resp(2'b01);

        // Reset during READ; rr is 1 here so requester 1 wins first.
        req_valid = 2'b11;
        req_addr  = {2'd2, 2'd3};
        #1;
        chk("pre_rst_grant", 32'(req_ready), 32'b10);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_mem_addr", 32'(mem_addr_r), 32'd0);
        chk("mid_rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("held_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        reset_n = 1'b1;
        accept_read(2'b11, 2'd3, 2'd2, 2'b01, 2'd3);
        resp_check(2'b01, 26'd4444);
        finish_resp(2'b01);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
